// File: rtl/cmp_sar_search.sv
// -----------------------------------------------------------------------------
// cmp_sar_search
//
// Successive-approximation search engine that sits on the initiator side of
// the 32-bit ALU magnitude comparator. The comparator is wired as
// a = target (hidden operand), b = cand_o. One candidate is driven per clock.
// The Gr/Lt/Eq answer comes back combinationally and is consumed in the same
// cycle. The engine converges on the target in at most 32 probes.
//
// Ports
//   clk         : system clock, rising edge
//   rst_n       : asynchronous active-low reset
//   start_i     : request a search (sampled only while idle)
//   sign_i      : 1 = signed (two's complement) search, 0 = unsigned; latched on start
//   cand_o      : candidate operand to comparator input b
//   cmp_sign_o  : comparator sign-mode input (latched sign)
//   cmp_gr_i    : comparator says target >  cand_o
//   cmp_lt_i    : comparator says target <  cand_o
//   cmp_eq_i    : comparator says target == cand_o
//   busy_o      : high while probing
//   done_o      : one-cycle completion pulse
//   result_o    : found value, held until the next search completes
//   err_o       : comparator gave an invalid (not one-hot) answer
//   probes_o    : number of probes used by the last search (1..32)
// -----------------------------------------------------------------------------
module cmp_sar_search (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        sign_i,
    output logic [31:0] cand_o,
    output logic        cmp_sign_o,
    input  logic        cmp_gr_i,
    input  logic        cmp_lt_i,
    input  logic        cmp_eq_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] result_o,
    output logic        err_o,
    output logic [5:0]  probes_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PROBE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_reg,  state_next;
    logic [31:0] off_reg,    off_next;     // partial result, offset-binary
    logic [4:0]  k_reg,      k_next;       // bit currently being resolved
    logic        sign_reg,   sign_next;
    logic [5:0]  count_reg,  count_next;   // probes issued so far in this search
    logic [31:0] cand_reg,   cand_next;    // last candidate, held outside PROBE
    logic [31:0] result_reg, result_next;
    logic        err_reg,    err_next;
    logic [5:0]  probes_reg, probes_next;

    // Offset-binary trick: flipping the MSB maps the signed range
    // 8000_0000..7FFF_FFFF monotonically onto 0000_0000..FFFF_FFFF. The same
    // unsigned bisection then works for both modes.
    logic [31:0] smask;
    logic [31:0] probe_bit;
    logic [31:0] off_raised;
    logic [31:0] cand_probe;
    logic        resp_valid;

    assign smask      = sign_reg ? 32'h8000_0000 : 32'h0000_0000;
    assign probe_bit  = 32'h0000_0001 << k_reg;
    assign off_raised = off_reg | probe_bit;
    assign cand_probe = off_raised ^ smask;

    // Exactly one of the three comparator flags must be set.
    always_comb begin
        resp_valid = 1'b0;
        case ({cmp_gr_i, cmp_lt_i, cmp_eq_i})
            3'b100, 3'b010, 3'b001: resp_valid = 1'b1;
            default:                resp_valid = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        off_next    = off_reg;
        k_next      = k_reg;
        sign_next   = sign_reg;
        count_next  = count_reg;
        cand_next   = cand_reg;
        result_next = result_reg;
        err_next    = err_reg;
        probes_next = probes_reg;

        case (state_reg)
            IDLE: begin
                if (start_i) begin
                    sign_next  = sign_i;
                    off_next   = 32'h0000_0000;
                    k_next     = 5'd31;
                    count_next = 6'd0;
                    state_next = PROBE;
                end
            end

            PROBE: begin
                cand_next  = cand_probe;
                count_next = count_reg + 6'd1;
                if (!resp_valid) begin
                    err_next    = 1'b1;
                    result_next = 32'h0000_0000;
                    probes_next = count_reg + 6'd1;
                    state_next  = DONE;
                end else if (cmp_eq_i) begin
                    // Exact hit: no need to resolve the remaining bits.
                    err_next    = 1'b0;
                    result_next = cand_probe;
                    probes_next = count_reg + 6'd1;
                    state_next  = DONE;
                end else begin
                    // Target above the candidate keeps the trial bit.
                    if (cmp_gr_i) begin
                        off_next = off_raised;
                    end
                    if (k_reg == 5'd0) begin
                        err_next    = 1'b0;
                        result_next = (cmp_gr_i ? off_raised : off_reg) ^ smask;
                        probes_next = count_reg + 6'd1;
                        state_next  = DONE;
                    end else begin
                        k_next = k_reg - 5'd1;
                    end
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            off_reg    <= 32'h0000_0000;
            k_reg      <= 5'd0;
            sign_reg   <= 1'b0;
            count_reg  <= 6'd0;
            cand_reg   <= 32'h0000_0000;
            result_reg <= 32'h0000_0000;
            err_reg    <= 1'b0;
            probes_reg <= 6'd0;
        end else begin
            state_reg  <= state_next;
            off_reg    <= off_next;
            k_reg      <= k_next;
            sign_reg   <= sign_next;
            count_reg  <= count_next;
            cand_reg   <= cand_next;
            result_reg <= result_next;
            err_reg    <= err_next;
            probes_reg <= probes_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // The candidate is live-combinational while probing (so the comparator
    // answer arrives in the same cycle). Otherwise the last candidate is held.
    assign cand_o     = (state_reg == PROBE) ? cand_probe : cand_reg;
    assign cmp_sign_o = sign_reg;
    assign busy_o     = (state_reg == PROBE);
    assign done_o     = (state_reg == DONE);
    assign result_o   = result_reg;
    assign err_o      = err_reg;
    assign probes_o   = probes_reg;

endmodule

// File: tb/tb_cmp_sar_search.sv
module tb_cmp_sar_search;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic        sign_i;
    logic [31:0] cand_o;
    logic        cmp_sign_o;
    logic        cmp_gr_i;
    logic        cmp_lt_i;
    logic        cmp_eq_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;
    logic        err_o;
    logic [5:0]  probes_o;

    cmp_sar_search dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .sign_i     (sign_i),
        .cand_o     (cand_o),
        .cmp_sign_o (cmp_sign_o),
        .cmp_gr_i   (cmp_gr_i),
        .cmp_lt_i   (cmp_lt_i),
        .cmp_eq_i   (cmp_eq_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .result_o   (result_o),
        .err_o      (err_o),
        .probes_o   (probes_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- comparator model with fault injection ----------------
    logic [31:0] target;
    int          fault_mode;   // 0 none, 1 gr=lt=1, 2 no response
    int          fault_at;     // probe number (1-based) to corrupt
    int          tb_probe;     // 1-based index of the current probe cycle

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)       tb_probe <= 1;
        else if (!busy_o) tb_probe <= 1;
        else              tb_probe <= tb_probe + 1;
    end

    always_comb begin
        cmp_gr_i = 1'b0;
        cmp_lt_i = 1'b0;
        cmp_eq_i = 1'b0;
        if (cmp_sign_o) begin
            cmp_gr_i = $signed(target) > $signed(cand_o);
            cmp_lt_i = $signed(target) < $signed(cand_o);
        end else begin
            cmp_gr_i = target > cand_o;
            cmp_lt_i = target < cand_o;
        end
        cmp_eq_i = (target == cand_o);
        if (busy_o && fault_mode != 0 && tb_probe == fault_at) begin
            cmp_gr_i = (fault_mode == 1);
            cmp_lt_i = (fault_mode == 1);
            cmp_eq_i = 1'b0;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] result;
        logic        err;
        logic [5:0]  probes;
        int          done_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, req, cyc);
    endtask

    // Reference: bisection in offset-binary space stops at the lowest set bit
    // of the mapped target (exact hit), or runs all 32 steps when it is zero.
    function automatic int natural_probes(input logic [31:0] t, input logic s);
        logic [31:0] u;
        int tz;
        u = s ? (t ^ 32'h8000_0000) : t;
        if (u == 32'h0) return 32;
        tz = 0;
        while (u[tz] == 1'b0) tz++;
        return 32 - tz;
    endfunction

    function automatic exp_t model(input logic [31:0] t, input logic s,
                                   input int fm, input int fa, input int start_cyc);
        exp_t e;
        int   p;
        p = natural_probes(t, s);
        if (fm != 0 && fa <= p) begin
            e.result = 32'h0;
            e.err    = 1'b1;
            e.probes = 6'(fa);
        end else begin
            e.result = t;
            e.err    = 1'b0;
            e.probes = 6'(p);
        end
        e.done_cyc = start_cyc + int'(e.probes) + 1;
        return e;
    endfunction

    // Monitor: one line per completed transaction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && done_o) begin
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_done: got done_o=1 expected no pending search (cycle %0d)", cyc);
                end else begin
                    passed++;
                    e = exp_q.pop_front();
                    $display("txn done: result=%08h err=%0b probes=%0d cycle=%0d", result_o, err_o, probes_o, cyc);
                    chk("result", result_o, e.result);
                    chk("err", 32'(err_o), 32'(e.err));
                    chk("probes", 32'(probes_o), 32'(e.probes));
                    chk("latency", 32'(cyc), 32'(e.done_cyc));
                end
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || busy_o || done_o) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            $display("FAIL idle_timeout: got busy=%0b pending=%0d expected idle", busy_o, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        @(negedge clk);
        while (!done_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            $display("FAIL done_timeout: got done_o=0 expected a pulse");
        end
    endtask

    // b2b=1: issue start during the DONE cycle of the running search and keep
    // it high so the following IDLE cycle accepts it.
    task automatic run_search(input logic [31:0] t, input logic s, input int fm,
                              input int fa, input bit b2b);
        int s_cyc;
        if (b2b) wait_done();
        else     wait_idle();
        target     = t;
        sign_i     = s;
        fault_mode = fm;
        fault_at   = fa;
        start_i    = 1'b1;
        s_cyc      = b2b ? cyc + 1 : cyc;
        exp_q.push_back(model(t, s, fm, fa, s_cyc));
        @(posedge clk);
        if (b2b) @(posedge clk);
        #1 start_i = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] t;
        logic        s;
        int          p, fm, fa;

        rst_n      = 1'b0;
        start_i    = 1'b0;
        sign_i     = 1'b0;
        target     = 32'h0;
        fault_mode = 0;
        fault_at   = 0;

        repeat (2) @(negedge clk);
        chk("rst_cand", cand_o, 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);
        chk("rst_done", 32'(done_o), 32'h0);
        chk("rst_result", result_o, 32'h0);
        chk("rst_err", 32'(err_o), 32'h0);
        chk("rst_probes", 32'(probes_o), 32'h0);
        chk("rst_sign", 32'(cmp_sign_o), 32'h0);
        rst_n = 1'b1;

        // Directed cases
        run_search(32'h8000_0000, 1'b0, 0, 0, 0);
        run_search(32'hFFFF_FFFF, 1'b0, 0, 0, 0);
        run_search(32'h0000_0000, 1'b0, 0, 0, 0);
        run_search(32'hFFFF_FFFF, 1'b1, 0, 0, 0);
        run_search(32'h8000_0000, 1'b1, 0, 0, 0);
        run_search(32'h7FFF_FFFF, 1'b1, 0, 0, 0);
        run_search(32'h1234_5679, 1'b0, 1, 3, 0);
        run_search(32'h1234_5679, 1'b0, 2, 3, 0);
        run_search(32'hDEAD_BEEF, 1'b1, 1, 32, 0);

        // Start (with a different sign) during PROBE must be ignored.
        run_search(32'h0F0F_0F0F, 1'b0, 0, 0, 0);
        repeat (3) @(negedge clk);
        start_i = 1'b1;
        sign_i  = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        chk("sign_held", 32'(cmp_sign_o), 32'h0);

        // Back-to-back start right after DONE.
        run_search(32'h0000_0001, 1'b0, 0, 0, 1);
        run_search(32'hC000_0000, 1'b1, 0, 0, 1);

        // Reset in the middle of a search: abort, no done.
        wait_idle();
        target     = 32'h1234_5679;
        sign_i     = 1'b1;
        fault_mode = 0;
        start_i    = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        begin
            int n;
            n = 0;
            while (!(busy_o && tb_probe == 10) && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("reach_probe10", 32'(n < 50), 32'h1);
        end
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cand", cand_o, 32'h0);
        chk("mid_rst_busy", 32'(busy_o), 32'h0);
        chk("mid_rst_done", 32'(done_o), 32'h0);
        chk("mid_rst_result", result_o, 32'h0);
        chk("mid_rst_err", 32'(err_o), 32'h0);
        chk("mid_rst_probes", 32'(probes_o), 32'h0);
        chk("mid_rst_sign", 32'(cmp_sign_o), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("post_rst_idle", 32'(busy_o), 32'h0);

        // Randomized searches
        for (int i = 0; i < 150; i++) begin
            t = $urandom;
            if ($urandom_range(0, 2) == 0) t = t & (32'hFFFF_FFFF << $urandom_range(0, 31));
            s  = 1'($urandom_range(0, 1));
            p  = natural_probes(t, s);
            fm = 0;
            fa = 0;
            if ($urandom_range(0, 5) == 0) begin
                fm = $urandom_range(1, 2);
                fa = $urandom_range(1, p);
            end
            run_search(t, s, fm, fa, ($urandom_range(0, 3) == 0));
        end
        wait_idle();
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
